// File: rtl/reorder_buffer_pkg.sv
// Shared types and sizing for the 32-entry, 2-wide reorder buffer.
// The optional flush port is enabled with the ROB_FLUSH_EN macro.
package reorder_buffer_pkg;
  localparam int TAG_W    = 5;
  localparam int DEPTH    = 1 << TAG_W;
  localparam int DATA_W   = 32;
  localparam int ARCH_W   = 5;
  localparam int WB_PORTS = 4;

  typedef logic [TAG_W-1:0]  tag_t;
  typedef logic [TAG_W:0]    cnt_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ARCH_W-1:0] arch_t;

  typedef enum logic [1:0] {WB_INT1, WB_INT2, WB_MUL, WB_LW} wb_port_e;

  typedef struct packed {
    logic  valid;
    tag_t  tag;
    data_t data;
  } wb_t;

  function automatic logic [1:0] pop2(input logic a, input logic b);
    return {1'b0, a} + {1'b0, b};
  endfunction
endpackage

// File: rtl/reorder_buffer_if.sv
// Allocation, writeback and commit signals between the core and the reorder buffer.
// The optional flush (ROB_FLUSH_EN) is a plain port on the top, not part of this bundle.
interface reorder_buffer_if;
  import reorder_buffer_pkg::*;

  logic  stall, we1, we2;
  arch_t wr_addr1, wr_addr2;
  tag_t  new_tag1, new_tag2;
  logic  rob_full;

  logic  we_INT1, we_INT2, we_MUL, we_LW;
  tag_t  INT_tag1, INT_tag2, MUL_tag, LW_tag;
  data_t INT_data1, INT_data2, MUL_data, LW_data;

  logic  C_we1, C_we2;
  arch_t C_addr1, C_addr2;
  data_t C_data1, C_data2;
  tag_t  C_p;

  modport master (
    output stall, we1, we2, wr_addr1, wr_addr2,
    output we_INT1, we_INT2, we_MUL, we_LW,
    output INT_tag1, INT_tag2, MUL_tag, LW_tag,
    output INT_data1, INT_data2, MUL_data, LW_data,
    input  new_tag1, new_tag2, rob_full,
    input  C_we1, C_we2, C_addr1, C_addr2, C_data1, C_data2, C_p
  );

  modport slave (
    input  stall, we1, we2, wr_addr1, wr_addr2,
    input  we_INT1, we_INT2, we_MUL, we_LW,
    input  INT_tag1, INT_tag2, MUL_tag, LW_tag,
    input  INT_data1, INT_data2, MUL_data, LW_data,
    output new_tag1, new_tag2, rob_full,
    output C_we1, C_we2, C_addr1, C_addr2, C_data1, C_data2, C_p
  );
endinterface

// File: rtl/reorder_buffer_rob_ptr_ctrl.sv
// Head/tail/count bookkeeping, full flag and tag grant for the reorder buffer.
// With ROB_FLUSH_EN defined, flush zeroes all three pointers.
module rob_ptr_ctrl
  import reorder_buffer_pkg::*;
(
  input  logic clk,
  input  logic rst,
`ifdef ROB_FLUSH_EN
  input  logic flush,
`endif
  input  logic stall,
  input  logic we1,
  input  logic we2,
  input  logic c_we1,
  input  logic c_we2,
  output tag_t head,
  output tag_t new_tag1,
  output tag_t new_tag2,
  output logic rob_full,
  output logic acc1,
  output logic acc2
);
  tag_t       tail;
  cnt_t       count;
  logic       acc;
  logic [1:0] n_alloc;
  logic [1:0] n_commit;

  // Full is judged on registered count only; same-cycle retirements do not free space.
  assign rob_full = count > cnt_t'(DEPTH - 2);
  assign acc      = ~stall & ~rob_full;
  assign acc1     = we1 & acc;
  assign acc2     = we2 & acc;
  assign n_alloc  = pop2(acc1, acc2);
  assign n_commit = pop2(c_we1, c_we2);

  assign new_tag1 = tail;
  assign new_tag2 = tail + tag_t'(we1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end
`ifdef ROB_FLUSH_EN
    else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end
`endif
    else begin
      // NOTE: non-blocking updates so all three pointers see the same pre-edge values.
      head  <= head + tag_t'(n_commit);
      tail  <= tail + tag_t'(n_alloc);
      count <= count + cnt_t'(n_alloc) - cnt_t'(n_commit);
    end
  end
endmodule

// File: rtl/reorder_buffer.sv
// Circular 32-entry, 2-wide reorder buffer: tag grant, 4-port writeback, in-order dual commit.
// Define ROB_FLUSH_EN to add the flush port that empties the buffer at an edge.
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic clk,
  input  logic rst,
`ifdef ROB_FLUSH_EN
  input  logic flush,
`endif
  reorder_buffer_if.slave rob
);
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] ready;
  arch_t            dst_q  [DEPTH];
  data_t            data_q [DEPTH];

  tag_t head, head1;
  logic c_we1, c_we2;
  logic acc1, acc2;
  tag_t new_tag1, new_tag2;
  wb_t  wb [WB_PORTS];

  rob_ptr_ctrl u_ptr (
    .clk      (clk),
    .rst      (rst),
`ifdef ROB_FLUSH_EN
    .flush    (flush),
`endif
    .stall    (rob.stall),
    .we1      (rob.we1),
    .we2      (rob.we2),
    .c_we1    (c_we1),
    .c_we2    (c_we2),
    .head     (head),
    .new_tag1 (new_tag1),
    .new_tag2 (new_tag2),
    .rob_full (rob.rob_full),
    .acc1     (acc1),
    .acc2     (acc2)
  );

  assign rob.new_tag1 = new_tag1;
  assign rob.new_tag2 = new_tag2;

  assign wb[WB_INT1] = '{valid: rob.we_INT1, tag: rob.INT_tag1, data: rob.INT_data1};
  assign wb[WB_INT2] = '{valid: rob.we_INT2, tag: rob.INT_tag2, data: rob.INT_data2};
  assign wb[WB_MUL]  = '{valid: rob.we_MUL,  tag: rob.MUL_tag,  data: rob.MUL_data};
  assign wb[WB_LW]   = '{valid: rob.we_LW,   tag: rob.LW_tag,   data: rob.LW_data};

  // Slot 2 only retires behind slot 1, keeping commit strictly in program order.
  assign head1 = head + tag_t'(1);
  assign c_we1 = busy[head] & ready[head];
  assign c_we2 = c_we1 & busy[head1] & ready[head1];

  assign rob.C_we1   = c_we1;
  assign rob.C_we2   = c_we2;
  assign rob.C_addr1 = dst_q[head];
  assign rob.C_addr2 = dst_q[head1];
  assign rob.C_data1 = data_q[head];
  assign rob.C_data2 = data_q[head1];
  assign rob.C_p     = head;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy  <= '0;
      ready <= '0;
    end
`ifdef ROB_FLUSH_EN
    else if (flush) begin
      busy  <= '0;
      ready <= '0;
    end
`endif
    else begin
      for (int p = 0; p < WB_PORTS; p++) begin
        if (wb[p].valid && busy[wb[p].tag]) ready[wb[p].tag] <= 1'b1;
      end
      if (c_we1) begin
        busy[head]  <= 1'b0;
        ready[head] <= 1'b0;
      end
      if (c_we2) begin
        busy[head1]  <= 1'b0;
        ready[head1] <= 1'b0;
      end
      if (acc1) begin
        busy[new_tag1]  <= 1'b1;
        ready[new_tag1] <= 1'b0;
      end
      if (acc2) begin
        busy[new_tag2]  <= 1'b1;
        ready[new_tag2] <= 1'b0;
      end
    end
  end

  // NOTE: payload arrays have no reset; busy/ready qualify every read, so stale contents are harmless.
  always_ff @(posedge clk) begin
    if (acc1) dst_q[new_tag1] <= rob.wr_addr1;
    if (acc2) dst_q[new_tag2] <= rob.wr_addr2;
    for (int p = 0; p < WB_PORTS; p++) begin
      if (wb[p].valid && busy[wb[p].tag]) data_q[wb[p].tag] <= wb[p].data;
    end
  end
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: vector table plus hand sequences for full, wrap, flush and reset.
// Build with ROB_FLUSH_EN defined to also exercise the flush port.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  logic clk = 1'b0;
  logic rst;
`ifdef ROB_FLUSH_EN
  logic flush;
`endif

  reorder_buffer_if rob_bus ();

  reorder_buffer dut (
    .clk   (clk),
    .rst   (rst),
`ifdef ROB_FLUSH_EN
    .flush (flush),
`endif
    .rob   (rob_bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       stall, we1, we2;
    arch_t      a1, a2;
    logic [3:0] wbv;
    tag_t       t_int1, t_int2, t_mul, t_lw;
    tag_t       e_tag1, e_tag2;
    logic       e_full, e_c1, e_c2;
    arch_t      e_a1, e_a2;
    tag_t       e_p;
  } vec_t;

  vec_t vec [14];

  function automatic vec_t mk(input int s, w1, w2, a1, a2, wbv, t1, t2, tm, tl,
                              et1, et2, ef, ec1, ec2, ea1, ea2, ep);
    vec_t v;
    v.stall = 1'(s);    v.we1 = 1'(w1);     v.we2 = 1'(w2);
    v.a1 = 5'(a1);      v.a2 = 5'(a2);      v.wbv = 4'(wbv);
    v.t_int1 = 5'(t1);  v.t_int2 = 5'(t2);  v.t_mul = 5'(tm);  v.t_lw = 5'(tl);
    v.e_tag1 = 5'(et1); v.e_tag2 = 5'(et2); v.e_full = 1'(ef);
    v.e_c1 = 1'(ec1);   v.e_c2 = 1'(ec2);
    v.e_a1 = 5'(ea1);   v.e_a2 = 5'(ea2);   v.e_p = 5'(ep);
    return v;
  endfunction

  function automatic data_t wdata(input tag_t t);
    return {24'hC0FFEE, 3'b101, t};
  endfunction

  function automatic arch_t dst_of(input tag_t t);
    return t ^ 5'h15;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    rob_bus.stall = 1'b0; rob_bus.we1 = 1'b0; rob_bus.we2 = 1'b0;
    rob_bus.wr_addr1 = '0; rob_bus.wr_addr2 = '0;
    rob_bus.we_INT1 = 1'b0; rob_bus.we_INT2 = 1'b0; rob_bus.we_MUL = 1'b0; rob_bus.we_LW = 1'b0;
    rob_bus.INT_tag1 = '0; rob_bus.INT_tag2 = '0; rob_bus.MUL_tag = '0; rob_bus.LW_tag = '0;
    rob_bus.INT_data1 = '0; rob_bus.INT_data2 = '0; rob_bus.MUL_data = '0; rob_bus.LW_data = '0;
`ifdef ROB_FLUSH_EN
    flush = 1'b0;
`endif
  endtask

  // v bits: [3] INT1, [2] INT2, [1] MUL, [0] LW; data is always wdata(tag).
  task automatic set_wb(input logic [3:0] v, input tag_t t1, t2, tm, tl);
    rob_bus.we_INT1 = v[3]; rob_bus.INT_tag1 = t1; rob_bus.INT_data1 = wdata(t1);
    rob_bus.we_INT2 = v[2]; rob_bus.INT_tag2 = t2; rob_bus.INT_data2 = wdata(t2);
    rob_bus.we_MUL  = v[1]; rob_bus.MUL_tag  = tm; rob_bus.MUL_data  = wdata(tm);
    rob_bus.we_LW   = v[0]; rob_bus.LW_tag   = tl; rob_bus.LW_data   = wdata(tl);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    tag_t p1;
    tag_t exp_head;
    int   n;

    //           st w1 w2 a1 a2 wbv      i1 i2 mu lw  et1 et2 f c1 c2 ea1 ea2 p
    vec[0]  = mk(0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0,  0,  0,  0, 0, 0, 0,  0,  0);
    vec[1]  = mk(0, 1, 1, 3, 4, 4'b0000, 0, 0, 0, 0,  0,  1,  0, 0, 0, 0,  0,  0);
    vec[2]  = mk(0, 0, 0, 0, 0, 4'b0100, 0, 1, 0, 0,  2,  2,  0, 0, 0, 0,  0,  0);
    vec[3]  = mk(0, 0, 0, 0, 0, 4'b1000, 0, 0, 0, 0,  2,  2,  0, 0, 0, 0,  0,  0);
    vec[4]  = mk(0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0,  2,  2,  0, 1, 1, 3,  4,  0);
    vec[5]  = mk(0, 1, 1, 5, 6, 4'b0000, 0, 0, 0, 0,  2,  3,  0, 0, 0, 0,  0,  2);
    vec[6]  = mk(0, 1, 0, 7, 0, 4'b0000, 0, 0, 0, 0,  4,  5,  0, 0, 0, 0,  0,  2);
    vec[7]  = mk(0, 0, 1, 0, 9, 4'b0000, 0, 0, 0, 0,  5,  5,  0, 0, 0, 0,  0,  2);
    vec[8]  = mk(0, 0, 0, 0, 0, 4'b1011, 5, 0, 3, 2,  6,  6,  0, 0, 0, 0,  0,  2);
    vec[9]  = mk(0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0,  6,  6,  0, 1, 1, 5,  6,  2);
    vec[10] = mk(0, 0, 0, 0, 0, 4'b1100, 4, 9, 0, 0,  6,  6,  0, 0, 0, 0,  0,  4);
    vec[11] = mk(0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0,  6,  6,  0, 1, 1, 7,  9,  4);
    vec[12] = mk(1, 1, 1, 1, 2, 4'b0000, 0, 0, 0, 0,  6,  7,  0, 0, 0, 0,  0,  6);
    vec[13] = mk(0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0,  6,  6,  0, 0, 0, 0,  0,  6);

    rst = 1'b1;
    idle();
    repeat (3) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      idle();
      rob_bus.stall = vec[i].stall;
      rob_bus.we1 = vec[i].we1;   rob_bus.we2 = vec[i].we2;
      rob_bus.wr_addr1 = vec[i].a1; rob_bus.wr_addr2 = vec[i].a2;
      set_wb(vec[i].wbv, vec[i].t_int1, vec[i].t_int2, vec[i].t_mul, vec[i].t_lw);
      #1;
      check($sformatf("v%0d new_tag1", i), 32'(rob_bus.new_tag1), 32'(vec[i].e_tag1));
      check($sformatf("v%0d new_tag2", i), 32'(rob_bus.new_tag2), 32'(vec[i].e_tag2));
      check($sformatf("v%0d rob_full", i), 32'(rob_bus.rob_full), 32'(vec[i].e_full));
      check($sformatf("v%0d C_we1", i),    32'(rob_bus.C_we1),    32'(vec[i].e_c1));
      check($sformatf("v%0d C_we2", i),    32'(rob_bus.C_we2),    32'(vec[i].e_c2));
      check($sformatf("v%0d C_p", i),      32'(rob_bus.C_p),      32'(vec[i].e_p));
      if (vec[i].e_c1) begin
        check($sformatf("v%0d C_addr1", i), 32'(rob_bus.C_addr1), 32'(vec[i].e_a1));
        check($sformatf("v%0d C_data1", i), rob_bus.C_data1, wdata(vec[i].e_p));
      end
      if (vec[i].e_c2) begin
        p1 = vec[i].e_p + 5'd1;
        check($sformatf("v%0d C_addr2", i), 32'(rob_bus.C_addr2), 32'(vec[i].e_a2));
        check($sformatf("v%0d C_data2", i), rob_bus.C_data2, wdata(p1));
      end
    end

    // Full boundary: head = tail = 6, empty. Fill 30, then one more reaches 31 -> full.
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      idle();
      rob_bus.we1 = 1'b1; rob_bus.wr_addr1 = dst_of(tag_t'(6 + 2 * i));
      rob_bus.we2 = 1'b1; rob_bus.wr_addr2 = dst_of(tag_t'(7 + 2 * i));
    end
    @(negedge clk);
    idle();
    #1;
    check("30 used rob_full", 32'(rob_bus.rob_full), 32'd0);
    check("30 used new_tag1", 32'(rob_bus.new_tag1), 32'd4);
    rob_bus.we1 = 1'b1; rob_bus.wr_addr1 = dst_of(5'd4);
    @(negedge clk);
    idle();
    rob_bus.we1 = 1'b1; rob_bus.we2 = 1'b1;
    #1;
    check("31 used rob_full", 32'(rob_bus.rob_full), 32'd1);
    check("31 used new_tag1", 32'(rob_bus.new_tag1), 32'd5);
    @(negedge clk);
    idle();
    #1;
    check("full ignores alloc new_tag1", 32'(rob_bus.new_tag1), 32'd5);
    check("full ignores alloc rob_full", 32'(rob_bus.rob_full), 32'd1);
    set_wb(4'b1000, 5'd6, 5'd0, 5'd0, 5'd0);
    @(negedge clk);
    idle();
    rob_bus.we1 = 1'b1;
    #1;
    check("full commit C_we1",    32'(rob_bus.C_we1),    32'd1);
    check("full commit C_we2",    32'(rob_bus.C_we2),    32'd0);
    check("full commit C_p",      32'(rob_bus.C_p),      32'd6);
    check("full commit C_addr1",  32'(rob_bus.C_addr1),  32'(dst_of(5'd6)));
    check("full commit rob_full", 32'(rob_bus.rob_full), 32'd1);
    @(negedge clk);
    idle();
    #1;
    check("after commit rob_full", 32'(rob_bus.rob_full), 32'd0);
    check("after commit new_tag1", 32'(rob_bus.new_tag1), 32'd5);
    check("after commit C_p",      32'(rob_bus.C_p),      32'd7);

    // Wrap: complete tags 7..30, let head drain to 31, then finish 31 and 0 together.
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      idle();
      set_wb(4'b1111, tag_t'(7 + 4 * k), tag_t'(8 + 4 * k), tag_t'(9 + 4 * k), tag_t'(10 + 4 * k));
    end
    @(negedge clk);
    idle();
    #1;
    n = 0;
    while (rob_bus.C_p !== 5'd31 && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("wrap head reaches 31", 32'(rob_bus.C_p), 32'd31);
    check("wrap head not ready C_we1", 32'(rob_bus.C_we1), 32'd0);
    set_wb(4'b1010, 5'd31, 5'd0, 5'd0, 5'd0);
    @(negedge clk);
    idle();
    #1;
    check("wrap C_we1",   32'(rob_bus.C_we1),   32'd1);
    check("wrap C_we2",   32'(rob_bus.C_we2),   32'd1);
    check("wrap C_p",     32'(rob_bus.C_p),     32'd31);
    check("wrap C_addr1", 32'(rob_bus.C_addr1), 32'(dst_of(5'd31)));
    check("wrap C_addr2", 32'(rob_bus.C_addr2), 32'(dst_of(5'd0)));
    check("wrap C_data1", rob_bus.C_data1, wdata(5'd31));
    check("wrap C_data2", rob_bus.C_data2, wdata(5'd0));
    @(negedge clk);
    #1;
    check("wrap head after", 32'(rob_bus.C_p),   32'd1);
    check("wrap idle C_we1", 32'(rob_bus.C_we1), 32'd0);

    exp_head = 5'd1;
`ifdef ROB_FLUSH_EN
    // 4 entries busy; add 6 to reach 10, then flush over a same-cycle alloc and writeback.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      idle();
      rob_bus.we1 = 1'b1; rob_bus.we2 = 1'b1;
      rob_bus.wr_addr1 = dst_of(tag_t'(5 + 2 * i)); rob_bus.wr_addr2 = dst_of(tag_t'(6 + 2 * i));
    end
    @(negedge clk);
    idle();
    flush = 1'b1;
    rob_bus.we1 = 1'b1;
    set_wb(4'b1000, 5'd1, 5'd0, 5'd0, 5'd0);
    @(negedge clk);
    idle();
    #1;
    check("flush new_tag1", 32'(rob_bus.new_tag1), 32'd0);
    check("flush C_p",      32'(rob_bus.C_p),      32'd0);
    check("flush C_we1",    32'(rob_bus.C_we1),    32'd0);
    check("flush rob_full", 32'(rob_bus.rob_full), 32'd0);
    set_wb(4'b1000, 5'd2, 5'd0, 5'd0, 5'd0);
    @(negedge clk);
    idle();
    #1;
    check("flush stale wb C_we1", 32'(rob_bus.C_we1),    32'd0);
    check("flush stale wb tag",   32'(rob_bus.new_tag1), 32'd0);
    rob_bus.we1 = 1'b1; rob_bus.we2 = 1'b1;
    rob_bus.wr_addr1 = dst_of(5'd0); rob_bus.wr_addr2 = dst_of(5'd1);
    exp_head = 5'd0;
`endif

    // Asynchronous reset in the middle of a cycle with a commit pending.
    @(negedge clk);
    idle();
    set_wb(4'b1000, exp_head, 5'd0, 5'd0, 5'd0);
    @(negedge clk);
    idle();
    #1;
    check("pre-reset C_we1",    32'(rob_bus.C_we1),   32'd1);
    check("pre-reset C_addr1",  32'(rob_bus.C_addr1), 32'(dst_of(exp_head)));
    #2;
    rst = 1'b1;
    #1;
    check("async rst C_we1",    32'(rob_bus.C_we1),    32'd0);
    check("async rst C_p",      32'(rob_bus.C_p),      32'd0);
    check("async rst new_tag1", 32'(rob_bus.new_tag1), 32'd0);
    check("async rst rob_full", 32'(rob_bus.rob_full), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("post rst C_we1",    32'(rob_bus.C_we1),    32'd0);
    check("post rst new_tag1", 32'(rob_bus.new_tag1), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
